// File: rtl/fault_monitor_if.sv
// fault_monitor_if: feature-average inputs, operator clear and status outputs of the fault monitor.
interface fault_monitor_if #(parameter int W = 16);
  logic         avg_valid;
  logic [W-1:0] avg_current;
  logic [W-1:0] avg_vibration;
  logic [W-1:0] avg_temperature;
  logic         fault_clear;
  logic [1:0]   state;
  logic         warn;
  logic         trip;
  logic [2:0]   fault_code;
  logic [7:0]   trip_count;
  modport master (
    output avg_valid, avg_current, avg_vibration, avg_temperature, fault_clear,
    input  state, warn, trip, fault_code, trip_count
  );
  modport slave (
    input  avg_valid, avg_current, avg_vibration, avg_temperature, fault_clear,
    output state, warn, trip, fault_code, trip_count
  );
endinterface

// File: rtl/fault_monitor.sv
// fault_monitor: per-channel warn/trip thresholds with persistence and hysteresis,
// driving a latched fault FSM with gated operator clear and cooldown.
module fault_monitor #(
  parameter int W       = 16,
  parameter int I_WARN  = 800,
  parameter int I_TRIP  = 1000,
  parameter int V_WARN  = 300,
  parameter int V_TRIP  = 500,
  parameter int T_WARN  = 600,
  parameter int T_TRIP  = 750,
  parameter int PERSIST = 3,
  parameter int HYST    = 20,
  parameter int COOL    = 4
) (
  input logic clk,
  input logic rst_n,
  fault_monitor_if.slave bus
);
  typedef enum logic [1:0] {NORMAL, WARNING, FAULT, COOLDOWN} state_t;
  localparam logic [3:0] PMAX = 4'(PERSIST);
  localparam logic [3:0] CMAX = 4'(COOL);
  state_t       state, state_n;
  logic [2:0]   code, code_n, ot, ow, be, tripped;
  logic [7:0]   count, count_n;
  logic [3:0]   cool, cool_n;
  logic [3:0]   pcnt [3];
  logic [3:0]   pupd [3];
  logic [W-1:0] avg [3];
  logic         v, quiet, quiet_n, clr_p, entry, any_warn, all_exit;
  assign v      = bus.avg_valid;
  assign avg[0] = bus.avg_current;
  assign avg[1] = bus.avg_vibration;
  assign avg[2] = bus.avg_temperature;
  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int WR = g == 0 ? I_WARN : g == 1 ? V_WARN : T_WARN;
    localparam int TR = g == 0 ? I_TRIP : g == 1 ? V_TRIP : T_TRIP;
    // Exit level clamps at zero, which makes below-exit unreachable.
    localparam logic [W-1:0] EX = W'(WR > HYST ? WR - HYST : 0);
    assign ot[g]      = avg[g] >= W'(TR);
    assign ow[g]      = avg[g] >= W'(WR);
    assign be[g]      = avg[g] < EX;
    assign pupd[g]    = ot[g] ? (pcnt[g] == PMAX ? pcnt[g] : pcnt[g] + 4'd1) : 4'd0;
    assign tripped[g] = v && pupd[g] == PMAX;
  end
  assign any_warn = |ow;
  assign all_exit = &be;
  always_comb begin
    state_n = state;
    code_n  = code;
    cool_n  = cool;
    quiet_n = v ? all_exit : quiet;
    clr_p   = 1'b0;
    entry   = 1'b0;
    case (state)
      NORMAL, WARNING: begin
        if (v && |tripped) begin
          state_n = FAULT;
          code_n  = tripped;
          entry   = 1'b1;
        end else if (v && state == NORMAL && any_warn) state_n = WARNING;
        else if (v && state == WARNING && all_exit) state_n = NORMAL;
      end
      FAULT: begin
        code_n = v ? code | tripped : code;
        // Clear is judged on the quiet flag left by the previous sample.
        if (bus.fault_clear && quiet) begin
          state_n = COOLDOWN;
          cool_n  = 4'd0;
        end
      end
      default: begin
        if (v && any_warn) begin
          state_n = FAULT;
          code_n  = code | tripped;
          entry   = 1'b1;
        end else if (v && all_exit) begin
          cool_n = cool + 4'd1;
          if (cool + 4'd1 == CMAX) begin
            state_n = NORMAL;
            code_n  = 3'd0;
            clr_p   = 1'b1;
          end
        end else if (v) cool_n = 4'd0;
      end
    endcase
    count_n = entry && count != 8'hff ? count + 8'd1 : count;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      code  <= 3'd0;
      count <= 8'd0;
      cool  <= 4'd0;
      quiet <= 1'b1;
      for (int i = 0; i < 3; i++) pcnt[i] <= 4'd0;
    end else begin
      state <= state_n;
      code  <= code_n;
      count <= count_n;
      cool  <= cool_n;
      quiet <= quiet_n;
      for (int i = 0; i < 3; i++) pcnt[i] <= clr_p ? 4'd0 : v ? pupd[i] : pcnt[i];
    end
  end
  assign bus.state      = state;
  assign bus.warn       = state == WARNING;
  assign bus.trip       = state == FAULT;
  assign bus.fault_code = code;
  assign bus.trip_count = count;
endmodule

// File: tb/tb_fault_monitor.sv
// tb_fault_monitor: directed vector table, async-reset sequence and randomized
// stimulus against a behavioural model of the fault monitor.
module tb_fault_monitor;
  localparam int P  = 3;
  localparam int CL = 4;
  localparam int HY = 20;
  localparam int TRIP [3] = '{1000, 500, 750};
  localparam int WARN [3] = '{800, 300, 600};
  typedef struct {
    bit v;
    int c, vb, t;
    bit clr;
    int st, code, cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fault_monitor_if #(.W(16)) bus();
  fault_monitor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  vec_t tbl [$];
  int passed = 0;
  int total = 0;
  int m_state, m_code, m_count, m_quiet_run;
  bit m_quiet;
  int run [3];

  task automatic model_reset();
    m_state = 0; m_code = 0; m_count = 0; m_quiet_run = 0; m_quiet = 1'b1;
    for (int i = 0; i < 3; i++) run[i] = 0;
  endtask

  // Runs are unbounded over-trip streak lengths; a channel has tripped once its streak reaches P.
  task automatic model_step(input bit v, input int c, input int vb, input int t, input bit clr);
    int x [3];
    int trc;
    bit anyw, alle, oldq;
    x = '{c, vb, t};
    trc = 0; anyw = 0; alle = 1; oldq = m_quiet;
    if (v) begin
      for (int i = 0; i < 3; i++) begin
        run[i] = x[i] >= TRIP[i] ? run[i] + 1 : 0;
        if (run[i] >= P) trc |= (1 << i);
        if (x[i] >= WARN[i]) anyw = 1;
        if (!(x[i] < ((WARN[i] > HY) ? WARN[i] - HY : 0))) alle = 0;
      end
    end
    case (m_state)
      0, 1: begin
        if (v && trc != 0) begin
          m_state = 2; m_code = trc; m_count = m_count < 255 ? m_count + 1 : 255;
        end else if (v && m_state == 0 && anyw) m_state = 1;
        else if (v && m_state == 1 && alle) m_state = 0;
      end
      2: begin
        if (v) m_code |= trc;
        if (clr && oldq) begin m_state = 3; m_quiet_run = 0; end
      end
      default: begin
        if (v && anyw) begin
          m_state = 2; m_code |= trc; m_count = m_count < 255 ? m_count + 1 : 255;
        end else if (v && alle) begin
          m_quiet_run++;
          if (m_quiet_run >= CL) begin
            m_state = 0; m_code = 0;
            for (int i = 0; i < 3; i++) run[i] = 0;
          end
        end else if (v) m_quiet_run = 0;
      end
    endcase
    if (v) m_quiet = alle;
  endtask

  task automatic drive(input bit v, input int c, input int vb, input int t, input bit clr);
    bus.avg_valid = v; bus.avg_current = 16'(c); bus.avg_vibration = 16'(vb);
    bus.avg_temperature = 16'(t); bus.fault_clear = clr;
    @(posedge clk);
    model_step(v, c, vb, t, clr);
    #1;
    bus.avg_valid = 1'b0; bus.fault_clear = 1'b0;
  endtask

  task automatic check(input string name, input int st, input int code, input int cnt);
    total++;
    if (bus.state === 2'(st) && bus.warn === (st == 1) && bus.trip === (st == 2) &&
        bus.fault_code === 3'(code) && bus.trip_count === 8'(cnt)) passed++;
    else $display("FAIL %s: got state=%0d warn=%b trip=%b code=%b count=%0d, need state=%0d code=%b count=%0d",
                  name, bus.state, bus.warn, bus.trip, bus.fault_code, bus.trip_count, st, 3'(code), cnt);
  endtask

  task automatic add(input bit v, input int c, input int vb, input int t, input bit clr,
                     input int st, input int code, input int cnt);
    vec_t e;
    e.v = v; e.c = c; e.vb = vb; e.t = t; e.clr = clr; e.st = st; e.code = code; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  function automatic int pick(input int i);
    int r;
    int ex;
    r = int'($urandom_range(0, 9));
    ex = WARN[i] - HY;
    if (r < 4) return int'($urandom_range(0, 32'(ex - 1)));
    if (r == 4) return ex - 1 + int'($urandom_range(0, 1));
    if (r < 7) return int'($urandom_range(32'(ex), 32'(WARN[i] + 1)));
    return TRIP[i] - 1 + int'($urandom_range(0, 30));
  endfunction

  initial begin
    bus.avg_valid = 1'b0; bus.avg_current = '0; bus.avg_vibration = '0;
    bus.avg_temperature = '0; bus.fault_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) add(1, 500, 100, 400, 0, 0, 0, 0);
    add(1, 850, 100, 400, 0, 1, 0, 0);
    add(1, 790, 100, 400, 0, 1, 0, 0);
    add(1, 779, 100, 400, 0, 0, 0, 0);
    add(1, 500, 520, 400, 0, 1, 0, 0);
    add(1, 500, 520, 400, 0, 1, 0, 0);
    add(1, 500, 480, 400, 0, 1, 0, 0);
    add(1, 500, 520, 400, 0, 1, 0, 0);
    add(1, 500, 520, 400, 0, 1, 0, 0);
    add(1, 500, 520, 400, 0, 2, 2, 1);
    add(1, 500, 100, 760, 0, 2, 2, 1);
    add(1, 500, 100, 760, 0, 2, 2, 1);
    add(1, 500, 100, 760, 0, 2, 6, 1);
    add(0, 500, 100, 760, 1, 2, 6, 1);
    add(1, 500, 100, 400, 0, 2, 6, 1);
    add(0, 500, 100, 400, 1, 3, 6, 1);
    add(1, 500, 100, 400, 0, 3, 6, 1);
    add(1, 500, 100, 400, 0, 3, 6, 1);
    add(1, 805, 100, 400, 0, 2, 6, 2);
    add(1, 500, 100, 400, 0, 2, 6, 2);
    add(0, 500, 100, 400, 1, 3, 6, 2);
    add(1, 500, 100, 400, 0, 3, 6, 2);
    add(1, 500, 100, 400, 0, 3, 6, 2);
    add(1, 790, 100, 400, 0, 3, 6, 2);
    add(1, 500, 100, 400, 0, 3, 6, 2);
    add(1, 500, 100, 400, 0, 3, 6, 2);
    add(1, 500, 100, 400, 0, 3, 6, 2);
    add(1, 500, 100, 400, 0, 0, 0, 2);
    add(1, 1000, 100, 400, 0, 1, 0, 2);
    add(1, 1000, 100, 400, 0, 1, 0, 2);
    add(1, 1000, 100, 400, 0, 2, 1, 3);
    add(1, 500, 100, 400, 1, 2, 1, 3);
    add(1, 1000, 100, 400, 1, 3, 1, 3);
    add(1, 1000, 100, 400, 0, 2, 1, 4);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].vb, tbl[i].t, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].code, tbl[i].cnt);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_low", 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_release", 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, pick(0), pick(1), pick(2), $urandom_range(0, 4) == 0);
      check($sformatf("rand%0d", n), m_state, m_code, m_count);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
